// File: rtl/game_round_ctrl_pkg.sv
// Shared encodings for the dodge-game round sequencer: FSM states,
// status digit codes shown on the seven-segment display, countdown start.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_COUNT = 3'd2,
    ST_PLAY  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Codes 4'hA..4'hF render blank in the downstream 7-segment decoder
  localparam logic [3:0] DIG_IDLE  = 4'hA;
  localparam logic [3:0] DIG_PLAY  = 4'hB;
  localparam logic [3:0] DIG_OVER  = 4'hC;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  localparam logic [1:0] CD_START = 2'd3;

endpackage

// File: rtl/game_round_ctrl_if.sv
// Handshake/display bundle between the round sequencer and the rest of the game.
interface game_round_ctrl_if;
  logic       tick;
  logic       start;
  logic       coll1;
  logic       coll2;
  logic [2:0] sel;
  logic       game_clr;
  logic       scroll_step;
  logic       playing;
  logic [3:0] bcd_out;

  modport master (
    output tick, start, coll1, coll2, sel,
    input  game_clr, scroll_step, playing, bcd_out
  );

  modport slave (
    input  tick, start, coll1, coll2, sel,
    output game_clr, scroll_step, playing, bcd_out
  );
endinterface

// File: rtl/game_round_ctrl_bcd_score_cnt.sv
// Two-digit BCD survival counter; holds at 99 instead of wrapping.
module bcd_score_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic at_max;
  assign at_max = (tens == 4'd9) && (ones == 4'd9);

  // Score register: clear wins over increment, increment carries ones into tens
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc && !at_max) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: IDLE -> CLEAR -> COUNT (3-2-1) -> PLAY -> OVER.
// Gates and accelerates map scrolling, scores survival per player in BCD,
// and serves one BCD digit per display select.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int PERIOD_INIT = 8,
  parameter int PERIOD_MIN  = 2,
  parameter int LEVEL_STEPS = 16
) (
  input logic                clk,
  input logic                reset,
  game_round_ctrl_if.slave   bus
);

  localparam logic [3:0] P_INIT    = 4'(PERIOD_INIT);
  localparam logic [3:0] P_MIN     = 4'(PERIOD_MIN);
  localparam logic [7:0] STEP_LAST = 8'(LEVEL_STEPS - 1);

  state_t     state_q, state_d;
  logic [3:0] round_q;
  logic [3:0] period_q;
  logic [3:0] tick_cnt_q;
  logic [7:0] step_cnt_q;
  logic [1:0] cd_q;
  logic       scroll_p1;

  logic       both_coll;
  logic       play_tick;
  logic       step_fire;
  logic       game_clr_c;
  logic       playing_c;
  logic [3:0] digit;
  logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;

  // A double collision pre-empts any step that lands in the same cycle
  assign both_coll = bus.coll1 & bus.coll2;
  assign play_tick = (state_q == ST_PLAY) && bus.tick && !both_coll;
  assign step_fire = play_tick && (tick_cnt_q == period_q - 4'd1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    game_clr_c = 1'b0;
    playing_c  = 1'b0;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_CLEAR;
      ST_CLEAR: begin
        game_clr_c = 1'b1;
        state_d    = ST_COUNT;
      end
      ST_COUNT: if (bus.tick && cd_q == 2'd1) state_d = ST_PLAY;
      ST_PLAY: begin
        playing_c = 1'b1;
        if (both_coll) state_d = ST_OVER;
      end
      ST_OVER:  if (bus.start) state_d = ST_CLEAR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Round, countdown, tick/step counters and scroll speed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_q    <= 4'd0;
      period_q   <= P_INIT;
      tick_cnt_q <= 4'd0;
      step_cnt_q <= 8'd0;
      cd_q       <= CD_START;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          round_q    <= (round_q == 4'd9) ? 4'd0 : round_q + 4'd1;
          period_q   <= P_INIT;
          tick_cnt_q <= 4'd0;
          step_cnt_q <= 8'd0;
          cd_q       <= CD_START;
        end
        ST_COUNT: begin
          if (bus.tick) begin
            cd_q <= cd_q - 2'd1;
            if (cd_q == 2'd1) tick_cnt_q <= 4'd0;
          end
        end
        ST_PLAY: begin
          if (step_fire) begin
            tick_cnt_q <= 4'd0;
            if (step_cnt_q == STEP_LAST) begin
              step_cnt_q <= 8'd0;
              if (period_q != P_MIN) period_q <= period_q - 4'd1;
            end else begin
              step_cnt_q <= step_cnt_q + 8'd1;
            end
          end else if (play_tick) begin
            tick_cnt_q <= tick_cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Scroll pulse trails the completing tick by one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) scroll_p1 <= 1'b0;
    else        scroll_p1 <= step_fire;
  end

  bcd_score_cnt u_score_p1 (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == ST_CLEAR),
    .inc   (step_fire & ~bus.coll1),
    .tens  (p1_tens),
    .ones  (p1_ones)
  );

  bcd_score_cnt u_score_p2 (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == ST_CLEAR),
    .inc   (step_fire & ~bus.coll2),
    .tens  (p2_tens),
    .ones  (p2_ones)
  );

  // Display digit mux: status/countdown, round, then the two scores
  always_comb begin
    digit = DIG_BLANK;
    case (bus.sel)
      3'd0: begin
        case (state_q)
          ST_IDLE:  digit = DIG_IDLE;
          ST_COUNT: digit = {2'b00, cd_q};
          ST_PLAY:  digit = DIG_PLAY;
          ST_OVER:  digit = DIG_OVER;
          default:  digit = DIG_BLANK;
        endcase
      end
      3'd1:    digit = round_q;
      3'd2:    digit = p1_tens;
      3'd3:    digit = p1_ones;
      3'd4:    digit = p2_tens;
      3'd5:    digit = p2_ones;
      default: digit = DIG_BLANK;
    endcase
  end

  assign bus.game_clr    = game_clr_c;
  assign bus.playing     = playing_c;
  assign bus.scroll_step = scroll_p1;
  assign bus.bcd_out     = digit;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with default parameters (8 / 2 / 16).
module tb_game_round_ctrl;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  game_round_ctrl_if bus ();

  game_round_ctrl #(
    .PERIOD_INIT (8),
    .PERIOD_MIN  (2),
    .LEVEL_STEPS (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [2:0] s, output logic [3:0] d);
    bus.sel = s;
    #1;
    d = bus.bcd_out;
  endtask

  task automatic pulse_tick(output logic st);
    bus.tick = 1'b1;
    clk1();
    bus.tick = 1'b0;
    st = bus.scroll_step;
  endtask

  task automatic run_ticks(input int n, output int steps);
    logic st;
    steps = 0;
    for (int i = 0; i < n; i++) begin
      pulse_tick(st);
      if (st) steps++;
    end
  endtask

  task automatic run_steps(input int n, output int ticks, output bit ok);
    logic st;
    int   got;
    got   = 0;
    ticks = 0;
    while (got < n && ticks < 3000) begin
      pulse_tick(st);
      ticks++;
      if (st) got++;
    end
    ok = (got == n);
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    clk1();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] d;
    logic       st;
    reset = 1'b0;
    #3;
    n_cmp++; if (bus.playing !== 1'b0) begin n_bad++; $display("FAIL rst_playing: got %b want 0", bus.playing); end
    n_cmp++; if (bus.game_clr !== 1'b0) begin n_bad++; $display("FAIL rst_game_clr: got %b want 0", bus.game_clr); end
    n_cmp++; if (bus.scroll_step !== 1'b0) begin n_bad++; $display("FAIL rst_scroll: got %b want 0", bus.scroll_step); end
    peek(3'd0, d); n_cmp++; if (d !== 4'hA) begin n_bad++; $display("FAIL rst_sel0: got %h want a", d); end
    peek(3'd1, d); n_cmp++; if (d !== 4'h0) begin n_bad++; $display("FAIL rst_round: got %h want 0", d); end
    peek(3'd6, d); n_cmp++; if (d !== 4'hF) begin n_bad++; $display("FAIL rst_sel6: got %h want f", d); end
    peek(3'd7, d); n_cmp++; if (d !== 4'hF) begin n_bad++; $display("FAIL rst_sel7: got %h want f", d); end
    clk1();
    reset = 1'b1;
    clk1();
    // A tick in IDLE must not disturb anything
    pulse_tick(st);
    clk1();
    n_cmp++; if (bus.game_clr !== 1'b0) begin n_bad++; $display("FAIL idle_tick_clr: got %b want 0", bus.game_clr); end
    peek(3'd0, d); n_cmp++; if (d !== 4'hA) begin n_bad++; $display("FAIL idle_tick_sel0: got %h want a", d); end
  endtask

  task automatic test_start();
    logic [3:0] d;
    logic       st;
    start_pulse();
    n_cmp++; if (bus.game_clr !== 1'b1) begin n_bad++; $display("FAIL start_clr_hi: got %b want 1", bus.game_clr); end
    clk1();
    n_cmp++; if (bus.game_clr !== 1'b0) begin n_bad++; $display("FAIL start_clr_lo: got %b want 0", bus.game_clr); end
    peek(3'd1, d); n_cmp++; if (d !== 4'h1) begin n_bad++; $display("FAIL start_round: got %h want 1", d); end
    peek(3'd0, d); n_cmp++; if (d !== 4'h3) begin n_bad++; $display("FAIL cd3: got %h want 3", d); end
    // start during countdown is ignored
    start_pulse();
    n_cmp++; if (bus.game_clr !== 1'b0) begin n_bad++; $display("FAIL count_start_ign: got %b want 0", bus.game_clr); end
    pulse_tick(st);
    peek(3'd0, d); n_cmp++; if (d !== 4'h2) begin n_bad++; $display("FAIL cd2: got %h want 2", d); end
    pulse_tick(st);
    peek(3'd0, d); n_cmp++; if (d !== 4'h1) begin n_bad++; $display("FAIL cd1: got %h want 1", d); end
    n_cmp++; if (bus.playing !== 1'b0) begin n_bad++; $display("FAIL cd1_playing: got %b want 0", bus.playing); end
    pulse_tick(st);
    n_cmp++; if (bus.playing !== 1'b1) begin n_bad++; $display("FAIL play_rise: got %b want 1", bus.playing); end
    peek(3'd0, d); n_cmp++; if (d !== 4'hB) begin n_bad++; $display("FAIL play_sel0: got %h want b", d); end
  endtask

  task automatic test_scroll();
    logic [3:0] d;
    logic       st;
    int         s;
    run_ticks(7, s);
    n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL step_early: got %0d pulses want 0", s); end
    pulse_tick(st);
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL step_8th: got %b want 1", st); end
    clk1();
    n_cmp++; if (bus.scroll_step !== 1'b0) begin n_bad++; $display("FAIL step_width: got %b want 0", bus.scroll_step); end
    peek(3'd2, d); n_cmp++; if (d !== 4'h0) begin n_bad++; $display("FAIL s1_p1t: got %h want 0", d); end
    peek(3'd3, d); n_cmp++; if (d !== 4'h1) begin n_bad++; $display("FAIL s1_p1o: got %h want 1", d); end
    peek(3'd5, d); n_cmp++; if (d !== 4'h1) begin n_bad++; $display("FAIL s1_p2o: got %h want 1", d); end
    run_ticks(120, s);
    n_cmp++; if (s !== 15) begin n_bad++; $display("FAIL steps_16: got %0d want 15", s); end
    peek(3'd2, d); n_cmp++; if (d !== 4'h1) begin n_bad++; $display("FAIL s16_p1t: got %h want 1", d); end
    peek(3'd3, d); n_cmp++; if (d !== 4'h6) begin n_bad++; $display("FAIL s16_p1o: got %h want 6", d); end
    // Period has dropped to 7 ticks
    run_ticks(6, s);
    n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL p7_early: got %0d want 0", s); end
    pulse_tick(st);
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL p7_step: got %b want 1", st); end
  endtask

  task automatic test_coll1();
    logic [3:0] d;
    int         s;
    bus.coll1 = 1'b1;
    run_ticks(35, s);
    n_cmp++; if (s !== 5) begin n_bad++; $display("FAIL c1_steps: got %0d want 5", s); end
    peek(3'd2, d); n_cmp++; if (d !== 4'h1) begin n_bad++; $display("FAIL c1_p1t: got %h want 1", d); end
    peek(3'd3, d); n_cmp++; if (d !== 4'h7) begin n_bad++; $display("FAIL c1_p1o: got %h want 7", d); end
    peek(3'd4, d); n_cmp++; if (d !== 4'h2) begin n_bad++; $display("FAIL c1_p2t: got %h want 2", d); end
    peek(3'd5, d); n_cmp++; if (d !== 4'h2) begin n_bad++; $display("FAIL c1_p2o: got %h want 2", d); end
    run_ticks(6, s);
    // Second collision lands on the tick that would complete a step
    bus.coll2 = 1'b1;
    bus.tick  = 1'b1;
    clk1();
    bus.tick  = 1'b0;
    n_cmp++; if (bus.scroll_step !== 1'b0) begin n_bad++; $display("FAIL over_nostep: got %b want 0", bus.scroll_step); end
    n_cmp++; if (bus.playing !== 1'b0) begin n_bad++; $display("FAIL over_playing: got %b want 0", bus.playing); end
    peek(3'd0, d); n_cmp++; if (d !== 4'hC) begin n_bad++; $display("FAIL over_sel0: got %h want c", d); end
    peek(3'd5, d); n_cmp++; if (d !== 4'h2) begin n_bad++; $display("FAIL over_p2o: got %h want 2", d); end
    clk1();
    n_cmp++; if (bus.scroll_step !== 1'b0) begin n_bad++; $display("FAIL over_nostep2: got %b want 0", bus.scroll_step); end
  endtask

  task automatic test_new_round();
    logic [3:0] d;
    logic       st;
    int         s;
    bus.coll1 = 1'b0;
    bus.coll2 = 1'b0;
    // start coincident with tick counts as start only
    bus.start = 1'b1;
    bus.tick  = 1'b1;
    clk1();
    bus.start = 1'b0;
    bus.tick  = 1'b0;
    n_cmp++; if (bus.game_clr !== 1'b1) begin n_bad++; $display("FAIL nr_clr: got %b want 1", bus.game_clr); end
    clk1();
    peek(3'd1, d); n_cmp++; if (d !== 4'h2) begin n_bad++; $display("FAIL nr_round: got %h want 2", d); end
    peek(3'd0, d); n_cmp++; if (d !== 4'h3) begin n_bad++; $display("FAIL nr_cd: got %h want 3", d); end
    peek(3'd3, d); n_cmp++; if (d !== 4'h0) begin n_bad++; $display("FAIL nr_p1o: got %h want 0", d); end
    peek(3'd4, d); n_cmp++; if (d !== 4'h0) begin n_bad++; $display("FAIL nr_p2t: got %h want 0", d); end
    run_ticks(3, s);
    run_ticks(7, s);
    n_cmp++; if (s !== 0) begin n_bad++; $display("FAIL nr_period_early: got %0d want 0", s); end
    pulse_tick(st);
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL nr_period8: got %b want 1", st); end
  endtask

  task automatic test_saturate();
    logic [3:0] d;
    logic       st;
    int         t;
    bit         ok;
    bus.coll1 = 1'b1;
    run_steps(97, t, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sat_run97: step budget expired after %0d ticks", t); end
    n_cmp++; if (t !== 524) begin n_bad++; $display("FAIL sat_ticks: got %0d want 524", t); end
    peek(3'd4, d); n_cmp++; if (d !== 4'h9) begin n_bad++; $display("FAIL sat98_t: got %h want 9", d); end
    peek(3'd5, d); n_cmp++; if (d !== 4'h8) begin n_bad++; $display("FAIL sat98_o: got %h want 8", d); end
    peek(3'd3, d); n_cmp++; if (d !== 4'h1) begin n_bad++; $display("FAIL sat_p1o: got %h want 1", d); end
    run_steps(1, t, ok);
    peek(3'd5, d); n_cmp++; if (d !== 4'h9) begin n_bad++; $display("FAIL sat99_o: got %h want 9", d); end
    run_steps(2, t, ok);
    peek(3'd4, d); n_cmp++; if (d !== 4'h9) begin n_bad++; $display("FAIL sathold_t: got %h want 9", d); end
    peek(3'd5, d); n_cmp++; if (d !== 4'h9) begin n_bad++; $display("FAIL sathold_o: got %h want 9", d); end
    // Past the level boundary at step 112 the period stays at its floor of 2
    run_steps(12, t, ok);
    n_cmp++; if (t !== 24) begin n_bad++; $display("FAIL floor_ticks: got %0d want 24", t); end
    pulse_tick(st);
    n_cmp++; if (st !== 1'b0) begin n_bad++; $display("FAIL floor_t1: got %b want 0", st); end
    pulse_tick(st);
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL floor_t2: got %b want 1", st); end
  endtask

  task automatic test_round_wrap();
    logic [3:0] d;
    logic [3:0] exp_r;
    int         s;
    bus.coll1 = 1'b1;
    bus.coll2 = 1'b1;
    clk1();
    bus.coll1 = 1'b0;
    bus.coll2 = 1'b0;
    exp_r = 4'd2;
    for (int r = 0; r < 8; r++) begin
      exp_r = (exp_r == 4'd9) ? 4'd0 : exp_r + 4'd1;
      start_pulse();
      clk1();
      peek(3'd1, d); n_cmp++; if (d !== exp_r) begin n_bad++; $display("FAIL wrap_round%0d: got %h want %h", r, d, exp_r); end
      run_ticks(3, s);
      if (r < 7) begin
        bus.coll1 = 1'b1;
        bus.coll2 = 1'b1;
        clk1();
        bus.coll1 = 1'b0;
        bus.coll2 = 1'b0;
      end
    end
    run_ticks(8, s);
    n_cmp++; if (s !== 1) begin n_bad++; $display("FAIL wrap_step: got %0d want 1", s); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] d;
    reset = 1'b0;
    #2;
    n_cmp++; if (bus.playing !== 1'b0) begin n_bad++; $display("FAIL mid_playing: got %b want 0", bus.playing); end
    peek(3'd0, d); n_cmp++; if (d !== 4'hA) begin n_bad++; $display("FAIL mid_sel0: got %h want a", d); end
    peek(3'd1, d); n_cmp++; if (d !== 4'h0) begin n_bad++; $display("FAIL mid_round: got %h want 0", d); end
    peek(3'd2, d); n_cmp++; if (d !== 4'h0) begin n_bad++; $display("FAIL mid_p1t: got %h want 0", d); end
    peek(3'd3, d); n_cmp++; if (d !== 4'h0) begin n_bad++; $display("FAIL mid_p1o: got %h want 0", d); end
    peek(3'd5, d); n_cmp++; if (d !== 4'h0) begin n_bad++; $display("FAIL mid_p2o: got %h want 0", d); end
    clk1();
    reset = 1'b1;
    clk1();
    n_cmp++; if (bus.game_clr !== 1'b0) begin n_bad++; $display("FAIL mid_noclr: got %b want 0", bus.game_clr); end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.coll1 = 1'b0;
    bus.coll2 = 1'b0;
    bus.sel   = 3'd0;
    test_reset();
    test_start();
    test_scroll();
    test_coll1();
    test_new_round();
    test_saturate();
    test_round_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round sequencer for the two-player LED-matrix dodge game.
- Starts and clears a round, runs a 3-step countdown, then gates map scrolling and accelerates it as play goes on.
- Scores survival time per player in BCD and ends the round once both players have collided.
- Supplies one BCD digit per seven-segment select for the existing 7-segment decoder.

Parameters:
- PERIOD_INIT, 8, base ticks per scroll step at round start (2..15)
- PERIOD_MIN, 2, fastest scroll period in ticks (1..PERIOD_INIT)
- LEVEL_STEPS, 16, scroll steps between period decrements (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-clk-wide base time strobe
- start  in  1  one-clk-wide debounced start-key strobe
- coll1  in  1  sticky collision flag, player 1
- coll2  in  1  sticky collision flag, player 2
- sel  in  3  seven-segment digit select, 0..5
- game_clr  out  1  one-clk pulse that clears player positions, collision flags and the map index
- scroll_step  out  1  one-clk pulse that advances the map by one row
- playing  out  1  high in PLAY; key movement is honoured only while high
- bcd_out  out  4  digit for the current sel

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, round=0, scores=00/00, period=PERIOD_INIT, tick_cnt=0, step_cnt=0, cd=3.
  - All outputs 0, except bcd_out, which follows sel.
- States: IDLE, CLEAR, COUNT, PLAY, OVER. Encoding lives in the package.
- IDLE:
  - start -> CLEAR.
  - Other inputs are ignored.
- CLEAR (exactly 1 cycle):
  - game_clr=1.
  - Scores, tick_cnt and step_cnt are zeroed; period=PERIOD_INIT; cd=3.
  - round increments, wrapping 9->0.
  - Next state is COUNT.
- COUNT:
  - Each tick decrements cd.
  - A tick that arrives with cd=1 moves to PLAY with cd=0 and tick_cnt=0.
  - start is ignored.
- PLAY:
  - playing=1.
  - Each tick increments tick_cnt.
  - When tick_cnt reaches period-1 on a tick: tick_cnt resets to 0, scroll_step pulses in the next cycle (1-cycle latency from tick), and step_cnt increments.
  - On that same step, each player whose coll flag is 0 gets their score incremented in BCD (ones 9->0 with tens carry). Scores saturate at 99.
  - When step_cnt reaches LEVEL_STEPS-1 on a step: step_cnt resets to 0, and period decrements unless it already equals PERIOD_MIN.
  - coll1 and coll2 both 1 (sampled every cycle) -> OVER. This has priority over a coincident step: no step pulse and no score change.
  - start in PLAY is ignored.
- OVER:
  - playing=0; scores and round hold.
  - start -> CLEAR, which begins a new round.
- Input edge cases:
  - A start coincident with tick is treated as start only.
  - Ticks outside COUNT/PLAY are ignored.
  - Collision flags are only acted on in PLAY.
- Reset mid-round returns the block to IDLE immediately. No game_clr is issued on reset; the other blocks share the same reset.
- bcd_out (combinational from registers):
  - sel=0: cd in COUNT; 4'hA in IDLE; 4'hB in PLAY; 4'hC in OVER.
  - sel=1: round.
  - sel=2: p1 tens. sel=3: p1 ones.
  - sel=4: p2 tens. sel=5: p2 ones.
  - sel=6,7: 4'hF.
  - 4'hA..F render blank in the existing decoder.
- Widths: period and tick_cnt 4 bits, step_cnt 8 bits, cd 2 bits, each BCD digit 4 bits.

Decomposition:
- Package game_pkg holds:
  - the state encoding constants (IDLE=0, CLEAR=1, COUNT=2, PLAY=3, OVER=4, 3 bits);
  - the status digit codes A/B/C/F;
  - the countdown start value 3.
- One sub-module, bcd_score_cnt: a 2-digit BCD counter with clr, inc and a saturate-at-99 rule. It is instantiated twice, once per player.

Test Plan:
- Reset low mid-PLAY -> state IDLE, playing=0, bcd_out=4'hA at sel=0, scores 00/00 at sel 2..5.
- start in IDLE -> game_clr high exactly 1 cycle; round reads 1 at sel=1; then 3 ticks -> sel=0 reads 3,2,1, and playing rises on the cycle after the third tick.
- Defaults, PLAY, no collisions, 8 ticks -> exactly one scroll_step, 1 cycle after the 8th tick; both scores 01. After 16 steps, the period becomes 7 ticks.
- coll1=1 only, 5 further steps -> p1 score frozen, p2 +5. Then coll2=1 coincident with a step -> OVER, no step pulse, p2 unchanged.
- Preload p2 to 98 and run 3 steps -> p2 reads 99 and stays at 99.
- In OVER, start -> CLEAR, scores 00, period=PERIOD_INIT. Repeat until round 9 -> the next round reads 0.
